// File: rtl/serial_link_vc_arbiter.sv
// serial_link_vc_arbiter
//
// Shares one serial-link output among NumVc virtual channels. Each handshake
// carries one channel's data flit and, chosen independently, one channel's
// pending credits piggy-backed on it. When no data is waiting but some channel
// has reached CredForceThresh pending credits, a credit-only flit is sent.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   vc_valid_i / vc_ready_o   per-channel data handshake
//   vc_data_i                 per-channel payload
//   vc_cred_i                 per-channel credits waiting to be returned
//   vc_allow_cred_consume_o   one-hot, channel whose credits are on the link
//   vc_consume_cred_o         one-hot pulse, that channel's credits left
//   link_valid_o/link_ready_i link handshake
//   link_data_o, link_data_vc_o, link_cred_o, link_cred_vc_o, link_cred_only_o
//                             flit contents
module serial_link_vc_arbiter #(
  parameter int NumVc           = 2,
  parameter int DataWidth       = 32,
  parameter int CreditWidth     = 8,
  parameter int CredForceThresh = 4,
  parameter int VcIdWidth       = $clog2(NumVc)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumVc-1:0]                      vc_valid_i,
  output logic [NumVc-1:0]                      vc_ready_o,
  input  logic [NumVc-1:0][DataWidth-1:0]       vc_data_i,
  input  logic [NumVc-1:0][CreditWidth-1:0]     vc_cred_i,
  output logic [NumVc-1:0]                      vc_allow_cred_consume_o,
  output logic [NumVc-1:0]                      vc_consume_cred_o,
  output logic                                  link_valid_o,
  input  logic                                  link_ready_i,
  output logic [DataWidth-1:0]                  link_data_o,
  output logic [VcIdWidth-1:0]                  link_data_vc_o,
  output logic [CreditWidth-1:0]                link_cred_o,
  output logic [VcIdWidth-1:0]                  link_cred_vc_o,
  output logic                                  link_cred_only_o
);

  typedef enum logic [1:0] {
    FLIT_NONE = 2'd0,
    FLIT_DATA = 2'd1,
    FLIT_CRED = 2'd2
  } flit_e;

  localparam logic [CreditWidth-1:0] Thresh = CreditWidth'(CredForceThresh);
  localparam logic [VcIdWidth-1:0]   LastVc = VcIdWidth'(NumVc - 1);

  logic                 lock_q;
  logic [VcIdWidth-1:0] data_ptr_q, cred_ptr_q;
  logic [VcIdWidth-1:0] dsel_q, csel_q;
  flit_e                type_q;

  logic [VcIdWidth-1:0] dsel_live, csel_live, force_sel, nz_sel, idx;
  logic                 data_found, force_found, nz_found;
  flit_e                type_live;

  logic [VcIdWidth-1:0] dsel, csel;
  flit_e                flit_type;
  logic                 handshake, cred_sent;

  function automatic logic [VcIdWidth-1:0] wrap_add(input logic [VcIdWidth-1:0] ptr,
                                                    input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NumVc) s = s - NumVc;
    return VcIdWidth'(s);
  endfunction

  function automatic logic [VcIdWidth-1:0] next_ptr(input logic [VcIdWidth-1:0] p);
    return (p == LastVc) ? '0 : p + VcIdWidth'(1);
  endfunction

  // Live arbitration: data round-robin from data_ptr_q; credits prefer any
  // channel at/above threshold (searched from cred_ptr_q so simultaneous
  // crossings rotate), then any non-zero channel, else follow the data winner.
  always_comb begin
    dsel_live   = data_ptr_q;
    force_sel   = cred_ptr_q;
    nz_sel      = cred_ptr_q;
    data_found  = 1'b0;
    force_found = 1'b0;
    nz_found    = 1'b0;
    idx         = '0;
    for (int i = 0; i < NumVc; i++) begin
      idx = wrap_add(data_ptr_q, i);
      if (!data_found && vc_valid_i[idx]) begin
        dsel_live  = idx;
        data_found = 1'b1;
      end
      idx = wrap_add(cred_ptr_q, i);
      if (!force_found && (vc_cred_i[idx] >= Thresh)) begin
        force_sel   = idx;
        force_found = 1'b1;
      end
      if (!nz_found && (vc_cred_i[idx] != '0)) begin
        nz_sel   = idx;
        nz_found = 1'b1;
      end
    end
    if (force_found)   csel_live = force_sel;
    else if (nz_found) csel_live = nz_sel;
    else               csel_live = dsel_live;
    if (data_found)       type_live = FLIT_DATA;
    else if (force_found) type_live = FLIT_CRED;
    else                  type_live = FLIT_NONE;
  end

  // Flit presentation. A stalled flit is frozen through the lock registers;
  // only link_cred_o stays live, the owning channel holds it while allowed.
  // Everything is gated by rst_ni so an asserted reset silences the link at once.
  always_comb begin
    dsel                    = lock_q ? dsel_q : dsel_live;
    csel                    = lock_q ? csel_q : csel_live;
    flit_type               = lock_q ? type_q : type_live;
    link_valid_o            = rst_ni && (flit_type != FLIT_NONE);
    link_data_o             = '0;
    link_data_vc_o          = '0;
    link_cred_o             = '0;
    link_cred_vc_o          = '0;
    link_cred_only_o        = 1'b0;
    vc_ready_o              = '0;
    vc_allow_cred_consume_o = '0;
    vc_consume_cred_o       = '0;
    if (link_valid_o) begin
      link_cred_o    = vc_cred_i[csel];
      link_cred_vc_o = csel;
      vc_allow_cred_consume_o[csel] = 1'b1;
      if (flit_type == FLIT_DATA) begin
        link_data_o    = vc_data_i[dsel];
        link_data_vc_o = dsel;
      end else begin
        link_data_vc_o   = csel;
        link_cred_only_o = 1'b1;
      end
    end
    handshake = link_valid_o && link_ready_i;
    cred_sent = handshake && (link_cred_o != '0);
    if (handshake && (flit_type == FLIT_DATA)) vc_ready_o[dsel] = 1'b1;
    if (cred_sent) vc_consume_cred_o[csel] = 1'b1;
  end

  // Lock on stall, release and advance pointers past the served channels on
  // handshake. Pointers only move for what actually left on the link.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      data_ptr_q <= '0;
      cred_ptr_q <= '0;
      dsel_q     <= '0;
      csel_q     <= '0;
      type_q     <= FLIT_NONE;
    end else if (handshake) begin
      lock_q <= 1'b0;
      if (flit_type == FLIT_DATA) data_ptr_q <= next_ptr(dsel);
      if (cred_sent)              cred_ptr_q <= next_ptr(csel);
    end else if (link_valid_o) begin
      lock_q <= 1'b1;
      dsel_q <= dsel;
      csel_q <= csel;
      type_q <= flit_type;
    end
  end

  // A channel must not withdraw a data flit that is already locked on the link.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (lock_q && (type_q == FLIT_DATA)) |-> vc_valid_i[dsel_q]);

endmodule

// File: tb/tb_serial_link_vc_arbiter.sv
// tb_serial_link_vc_arbiter
//
// Directed bench for serial_link_vc_arbiter with NumVc=2, DataWidth=32,
// CreditWidth=8, CredForceThresh=4. Each task drives one scenario and checks
// the outputs against hand-computed values, one cycle at a time.
module tb_serial_link_vc_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       vc_valid;
  logic [1:0]       vc_ready;
  logic [1:0][31:0] vc_data;
  logic [1:0][7:0]  vc_cred;
  logic [1:0]       vc_allow;
  logic [1:0]       vc_consume;
  logic             link_valid;
  logic             link_ready;
  logic [31:0]      link_data;
  logic [0:0]       link_data_vc;
  logic [7:0]       link_cred;
  logic [0:0]       link_cred_vc;
  logic             link_cred_only;

  int checks = 0;
  int passes = 0;

  serial_link_vc_arbiter #(
    .NumVc(2), .DataWidth(32), .CreditWidth(8), .CredForceThresh(4)
  ) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .vc_valid_i              (vc_valid),
    .vc_ready_o              (vc_ready),
    .vc_data_i               (vc_data),
    .vc_cred_i               (vc_cred),
    .vc_allow_cred_consume_o (vc_allow),
    .vc_consume_cred_o       (vc_consume),
    .link_valid_o            (link_valid),
    .link_ready_i            (link_ready),
    .link_data_o             (link_data),
    .link_data_vc_o          (link_data_vc),
    .link_cred_o             (link_cred),
    .link_cred_vc_o          (link_cred_vc),
    .link_cred_only_o        (link_cred_only)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are then driven 1ns after the edge and the
  // outputs sampled 2ns later, well clear of either clock edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni     = 1'b0;
    vc_valid   = '0;
    vc_data    = '0;
    vc_cred    = '0;
    link_ready = 1'b0;
    #12;
    checks++;
    if ({link_valid, link_cred_only, link_data_vc, link_cred_vc} !== 4'b0000)
      $display("[TB] FAIL reset_link got %b want 0000",
               {link_valid, link_cred_only, link_data_vc, link_cred_vc});
    else passes++;
    checks++;
    if ({vc_ready, vc_allow, vc_consume} !== 6'b0)
      $display("[TB] FAIL reset_vc got %b want 000000", {vc_ready, vc_allow, vc_consume});
    else passes++;
    checks++;
    if ({link_data, link_cred} !== 40'h0)
      $display("[TB] FAIL reset_payload got %h want 0", {link_data, link_cred});
    else passes++;
    #1 rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vc_valid   = 2'b11;
    vc_data[0] = 32'hA0A0_0000;
    vc_data[1] = 32'hB1B1_1111;
    vc_cred    = '0;
    link_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (link_data_vc !== exp_vc[c])
        $display("[TB] FAIL rr_vc cycle %0d got %0d want %0d", c, link_data_vc, exp_vc[c]);
      else passes++;
      checks++;
      if (vc_ready !== (exp_vc[c] ? 2'b10 : 2'b01))
        $display("[TB] FAIL rr_ready cycle %0d got %b want %b", c, vc_ready,
                 exp_vc[c] ? 2'b10 : 2'b01);
      else passes++;
      checks++;
      if ({vc_consume, link_cred} !== 10'h0)
        $display("[TB] FAIL rr_consume cycle %0d got %b/%0d want 00/0", c, vc_consume, link_cred);
      else passes++;
      checks++;
      if (link_data !== (exp_vc[c] ? 32'hB1B1_1111 : 32'hA0A0_0000))
        $display("[TB] FAIL rr_data cycle %0d got %h", c, link_data);
      else passes++;
      next_cycle();
    end
    vc_valid   = 2'b00;
    link_ready = 1'b0;
  endtask

  task automatic test_stall();
    vc_valid   = 2'b10;
    vc_cred[0] = 8'd3;
    link_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++;
      if ({link_valid, link_data_vc, link_cred_vc, link_cred} !== {1'b1, 1'b1, 1'b0, 8'd3})
        $display("[TB] FAIL stall_frozen cycle %0d got v%b dvc%0d cvc%0d cred%0d want v1 dvc1 cvc0 cred3",
                 c, link_valid, link_data_vc, link_cred_vc, link_cred);
      else passes++;
      checks++;
      if ({vc_ready, vc_consume, link_data} !== {4'b0000, 32'hB1B1_1111})
        $display("[TB] FAIL stall_quiet cycle %0d got rdy%b cons%b data%h",
                 c, vc_ready, vc_consume, link_data);
      else passes++;
      next_cycle();
      vc_valid = 2'b11;
    end
    link_ready = 1'b1;
    #2;
    checks++;
    if ({vc_ready, vc_consume, vc_allow} !== 6'b10_01_01)
      $display("[TB] FAIL stall_release got rdy%b cons%b allow%b want 10 01 01",
               vc_ready, vc_consume, vc_allow);
    else passes++;
    next_cycle();
    vc_valid   = 2'b00;
    vc_cred    = '0;
    link_ready = 1'b0;
  endtask

  task automatic test_cred_only();
    vc_cred[1] = 8'd4;
    link_ready = 1'b1;
    #2;
    checks++;
    if ({link_valid, link_cred_only, link_cred_vc, link_data_vc, link_cred} !== {4'b1111, 8'd4})
      $display("[TB] FAIL credonly_flit got v%b co%b cvc%0d dvc%0d cred%0d want 1 1 1 1 4",
               link_valid, link_cred_only, link_cred_vc, link_data_vc, link_cred);
    else passes++;
    checks++;
    if (link_data !== 32'h0)
      $display("[TB] FAIL credonly_data got %h want 0", link_data);
    else passes++;
    checks++;
    if ({vc_ready, vc_consume, vc_allow} !== 6'b00_10_10)
      $display("[TB] FAIL credonly_ctl got rdy%b cons%b allow%b want 00 10 10",
               vc_ready, vc_consume, vc_allow);
    else passes++;
    next_cycle();
    vc_cred    = '0;
    link_ready = 1'b0;
  endtask

  task automatic test_below_thresh();
    vc_cred    = {8'd3, 8'd3};
    link_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({link_valid, vc_allow, vc_consume} !== 5'b0)
        $display("[TB] FAIL below_idle cycle %0d got v%b allow%b cons%b want 0",
                 c, link_valid, vc_allow, vc_consume);
      else passes++;
      next_cycle();
    end
    vc_valid   = 2'b01;
    vc_data[0] = 32'hC0DE_0001;
    #2;
    checks++;
    if ({link_data, link_data_vc, link_cred_vc, link_cred} !== {32'hC0DE_0001, 1'b0, 1'b0, 8'd3})
      $display("[TB] FAIL below_first got data%h dvc%0d cvc%0d cred%0d want c0de0001 0 0 3",
               link_data, link_data_vc, link_cred_vc, link_cred);
    else passes++;
    checks++;
    if ({vc_ready, vc_consume} !== 4'b01_01)
      $display("[TB] FAIL below_first_ctl got rdy%b cons%b want 01 01", vc_ready, vc_consume);
    else passes++;
    next_cycle();
    vc_cred[0] = 8'd0;
    vc_data[0] = 32'hC0DE_0002;
    #2;
    checks++;
    if ({link_data_vc, link_cred_vc, link_cred} !== {1'b0, 1'b1, 8'd3})
      $display("[TB] FAIL below_second got dvc%0d cvc%0d cred%0d want 0 1 3",
               link_data_vc, link_cred_vc, link_cred);
    else passes++;
    checks++;
    if ({vc_ready, vc_consume} !== 4'b01_10)
      $display("[TB] FAIL below_second_ctl got rdy%b cons%b want 01 10", vc_ready, vc_consume);
    else passes++;
    next_cycle();
    vc_valid   = 2'b00;
    vc_cred    = '0;
    link_ready = 1'b0;
  endtask

  task automatic test_cred_fairness();
    logic [0:0] exp_vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vc_valid   = 2'b01;
    vc_cred    = {8'd5, 8'd5};
    link_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if ({link_cred_vc, link_cred, link_data_vc} !== {exp_vc[c], 8'd5, 1'b0})
        $display("[TB] FAIL fair_cvc cycle %0d got cvc%0d cred%0d dvc%0d want cvc%0d cred5 dvc0",
                 c, link_cred_vc, link_cred, link_data_vc, exp_vc[c]);
      else passes++;
      checks++;
      if (vc_consume !== (exp_vc[c] ? 2'b10 : 2'b01))
        $display("[TB] FAIL fair_consume cycle %0d got %b", c, vc_consume);
      else passes++;
      next_cycle();
    end
    vc_valid   = 2'b00;
    vc_cred    = '0;
    link_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    vc_valid   = 2'b10;
    link_ready = 1'b0;
    #2;
    checks++;
    if ({link_valid, link_data_vc} !== 2'b11)
      $display("[TB] FAIL rstmid_pre got v%b dvc%0d want 1 1", link_valid, link_data_vc);
    else passes++;
    next_cycle();
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({link_valid, link_data_vc, link_cred_only, vc_ready, vc_allow, vc_consume} !== 9'b0)
      $display("[TB] FAIL rstmid_zero got v%b dvc%0d co%b rdy%b allow%b cons%b want all 0",
               link_valid, link_data_vc, link_cred_only, vc_ready, vc_allow, vc_consume);
    else passes++;
    checks++;
    if (link_data !== 32'h0)
      $display("[TB] FAIL rstmid_data got %h want 0", link_data);
    else passes++;
    vc_valid   = 2'b11;
    link_ready = 1'b1;
    #1 rst_ni = 1'b1;
    #1;
    checks++;
    if ({link_data_vc, vc_ready} !== 3'b0_01)
      $display("[TB] FAIL rstmid_first got dvc%0d rdy%b want 0 01", link_data_vc, vc_ready);
    else passes++;
    next_cycle();
    #2;
    checks++;
    if ({link_data_vc, vc_ready} !== 3'b1_10)
      $display("[TB] FAIL rstmid_second got dvc%0d rdy%b want 1 10", link_data_vc, vc_ready);
    else passes++;
    next_cycle();
    vc_valid   = 2'b00;
    link_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_cred_only();
    test_below_thresh();
    test_cred_fairness();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
